// File: rtl/serial_link_obi_arbiter.sv
// Round-robin OBI arbiter that shares one serial-link OBI slave port between NumReq managers
// and routes each response back to its issuer through an in-order id FIFO.
module serial_link_obi_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               req_i,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq*(DataWidth/8)-1:0] be_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    output logic [NumReq-1:0]               gnt_o,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mst_req_o,
    output logic [AddrWidth-1:0]            mst_addr_o,
    output logic                            mst_we_o,
    output logic [DataWidth/8-1:0]          mst_be_o,
    output logic [DataWidth-1:0]            mst_wdata_o,
    input  logic                            mst_gnt_i,
    input  logic                            mst_rvalid_i,
    input  logic [DataWidth-1:0]            mst_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                            err_o
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned IdWidth  = $clog2(NumReq);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IdWidth-1:0]    hold_id_q, hold_id_d;
    logic [IdWidth-1:0]    rr_ptr_q;
    logic [IdWidth-1:0]    winner;
    logic [IdWidth-1:0]    sel_id;
    logic [IdWidth-1:0]    fifo_q [MaxOutstanding];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]   count_q;
    logic                  err_q;
    logic                  full;
    logic                  arb_valid;
    logic                  grant_fire;
    logic                  pop;

    assign full      = (count_q == CntWidth'(MaxOutstanding));
    assign arb_valid = !full && (|req_i);

    // First requester at or after rr_ptr, wrapping around
    always_comb begin
        int unsigned idx;
        logic        found;
        idx    = 0;
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!found && req_i[IdWidth'(idx)]) begin
                found  = 1'b1;
                winner = IdWidth'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB;
            hold_id_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_id_d = hold_id_q;
        case (state_q)
            ARB: begin
                if (arb_valid && !mst_gnt_i) begin
                    state_d   = HOLD;
                    hold_id_d = winner;
                end
            end
            HOLD: begin
                if (mst_gnt_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    // Address phase and response routing; everything is forced low while in reset
    always_comb begin
        mst_req_o   = 1'b0;
        sel_id      = winner;
        mst_addr_o  = '0;
        mst_we_o    = 1'b0;
        mst_be_o    = '0;
        mst_wdata_o = '0;
        case (state_q)
            ARB:     mst_req_o = arb_valid;
            HOLD: begin
                mst_req_o = 1'b1;
                sel_id    = hold_id_q;
            end
            default: mst_req_o = 1'b0;
        endcase
        mst_req_o  = mst_req_o && rst_ni;
        grant_fire = mst_req_o && mst_gnt_i;
        pop        = rst_ni && mst_rvalid_i && (count_q != '0);
        if (mst_req_o) begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (sel_id == IdWidth'(i)) begin
                    mst_addr_o  = addr_i[i*AddrWidth +: AddrWidth];
                    mst_we_o    = we_i[i];
                    mst_be_o    = be_i[i*BeWidth +: BeWidth];
                    mst_wdata_o = wdata_i[i*DataWidth +: DataWidth];
                end
            end
        end
        gnt_o    = grant_fire ? (NumReq'(1) << sel_id) : '0;
        rvalid_o = pop ? (NumReq'(1) << fifo_q[rd_ptr_q]) : '0;
        rdata_o  = rst_ni ? mst_rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (grant_fire) fifo_q[wr_ptr_q] <= sel_id;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant_fire) begin
                rr_ptr_q <= (sel_id == IdWidth'(NumReq - 1)) ? '0 : sel_id + IdWidth'(1);
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0
                                                                        : wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0
                                                                        : rd_ptr_q + PtrWidth'(1);
            end
            if (grant_fire && !pop)      count_q <= count_q + CntWidth'(1);
            else if (pop && !grant_fire) count_q <= count_q - CntWidth'(1);
            if (mst_rvalid_i && (count_q == '0)) err_q <= 1'b1;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_serial_link_obi_arbiter.sv
// Directed plus randomized bench for serial_link_obi_arbiter against a queue-based reference model.
module tb_serial_link_obi_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0]    we = '0;
    logic [N*BW-1:0] be = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            mst_req_o, mst_we_o;
    logic [AW-1:0]   mst_addr_o;
    logic [BW-1:0]   mst_be_o;
    logic [DW-1:0]   mst_wdata_o;
    logic            mst_gnt = 1'b0, mst_rvalid = 1'b0;
    logic [DW-1:0]   mst_rdata = '0;
    logic [CW-1:0]   outstanding_o;
    logic            err_o;

    int total = 0;
    int bad   = 0;

    // Reference model: round-robin pointer, pending (held) winner, FIFO of issuer ids, sticky error
    int m_rr   = 0;
    int m_hold = -1;
    int m_q[$];
    bit m_err  = 1'b0;

    serial_link_obi_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mst_req_o(mst_req_o), .mst_addr_o(mst_addr_o), .mst_we_o(mst_we_o),
        .mst_be_o(mst_be_o), .mst_wdata_o(mst_wdata_o),
        .mst_gnt_i(mst_gnt), .mst_rvalid_i(mst_rvalid), .mst_rdata_i(mst_rdata),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational/registered outputs, advance model
    task automatic step(input logic [N-1:0] r, input logic g, input logic rv, input logic [DW-1:0] rd);
        int          sel;
        bit          mreq;
        logic [N-1:0] e_gnt, e_rv;
        logic [63:0] e_fields;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        req        = r;
        mst_gnt    = g;
        mst_rvalid = rv;
        mst_rdata  = rd;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = $urandom;
            wdata[i*DW +: DW] = $urandom;
            be[i*BW +: BW]    = BW'($urandom);
            we[i]             = 1'($urandom);
        end
        #1;
        sel  = -1;
        mreq = 1'b0;
        if (m_hold >= 0) begin
            sel  = m_hold;
            mreq = 1'b1;
        end else if (m_q.size() < MO && r != '0) begin
            for (int k = 0; k < N; k++)
                if (sel < 0 && r[(m_rr + k) % N]) sel = (m_rr + k) % N;
            mreq = 1'b1;
        end
        e_gnt    = (mreq && g) ? N'(1 << sel) : '0;
        e_rv     = (rv && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
        e_addr   = '0;
        e_fields = '0;
        if (mreq) begin
            e_addr   = addr[sel*AW +: AW];
            e_fields = 64'({we[sel], be[sel*BW +: BW], wdata[sel*DW +: DW]});
        end
        check("mst_req", mst_req_o, mreq);
        check("gnt", gnt_o, e_gnt);
        check("rvalid", rvalid_o, e_rv);
        check("mst_addr", mst_addr_o, e_addr);
        check("mst_fields", 64'({mst_we_o, mst_be_o, mst_wdata_o}), e_fields);
        check("rdata", rdata_o, rd);
        check("outstanding", outstanding_o, m_q.size());
        check("err", err_o, m_err);
        if (rv) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
        end
        if (mreq && g) begin
            m_q.push_back(sel);
            m_rr   = (sel + 1) % N;
            m_hold = -1;
        end else if (mreq) begin
            m_hold = sel;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req        = '1;
        mst_gnt    = 1'b1;
        mst_rvalid = 1'b1;
        #1;
        check("rst_mst_req", mst_req_o, 0);
        check("rst_gnt", gnt_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_err", err_o, 0);
        @(negedge clk);
        req        = '0;
        mst_gnt    = 1'b0;
        mst_rvalid = 1'b0;
        rst_n      = 1'b1;
        m_rr   = 0;
        m_hold = -1;
        m_q.delete();
        m_err  = 1'b0;
    endtask

    initial begin
        do_reset();

        // T1: single read from req0, response two cycles later
        step(2'b01, 1'b1, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b1, 32'hDEADBEEF);

        // T2: both requesting with grant always high, then drain in issue order
        for (int i = 0; i < 4; i++) step(2'b11, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 1'b1, $urandom);

        // T3: req1 held off for three cycles while req0 joins
        step(2'b10, 1'b0, 1'b0, 32'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b1, $urandom);
        step(2'b00, 1'b0, 1'b1, $urandom);

        // T4: fill to capacity, pop does not grant in the same cycle
        for (int i = 0; i < 4; i++) step(2'b01, 1'b1, 1'b0, 32'h0);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        step(2'b01, 1'b1, 1'b1, $urandom);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 1'b1, $urandom);

        // T5: unsolicited response sets sticky error
        step(2'b00, 1'b0, 1'b1, $urandom);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b0, 32'h0);

        // T6: reset with transactions in flight, then tie goes to req0
        step(2'b01, 1'b1, 1'b0, 32'h0);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        do_reset();
        step(2'b11, 1'b1, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b1, $urandom);

        // Randomized traffic
        for (int i = 0; i < 500; i++)
            step(N'($urandom), ($urandom % 10) < 6, ($urandom % 10) < 4, $urandom);
        step(2'b00, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
